// File: rtl/flag_stack_unit_if.sv
// -----------------------------------------------------------------------------
// flag_stack_unit_if
// Bundles the flag-write, stack-control and status signals of flag_stack_unit.
//   master : drives flag_we, flag_mask, alu_flags, push, pop (and cond);
//            observes flags, flags_fwd, depth, stack_full, stack_empty,
//            ovf_err, unf_err (and cond_true).
//   slave  : the flag_stack_unit side (directions reversed).
// Optional macro FLAG_COND_EN adds cond[3:0] / cond_true.
// -----------------------------------------------------------------------------
interface flag_stack_unit_if #(
    parameter int NUM_FLAGS   = 4,
    parameter int STACK_DEPTH = 4,
    localparam int DW         = $clog2(STACK_DEPTH + 1)
);
    logic                 flag_we;
    logic [NUM_FLAGS-1:0] flag_mask;
    logic [NUM_FLAGS-1:0] alu_flags;
    logic                 push;
    logic                 pop;
    logic [NUM_FLAGS-1:0] flags;
    logic [NUM_FLAGS-1:0] flags_fwd;
    logic [DW-1:0]        depth;
    logic                 stack_full;
    logic                 stack_empty;
    logic                 ovf_err;
    logic                 unf_err;
`ifdef FLAG_COND_EN
    logic [3:0]           cond;
    logic                 cond_true;
`endif

    modport master (
        output flag_we, flag_mask, alu_flags, push, pop,
`ifdef FLAG_COND_EN
        output cond,
        input  cond_true,
`endif
        input  flags, flags_fwd, depth, stack_full, stack_empty, ovf_err, unf_err
    );

    modport slave (
        input  flag_we, flag_mask, alu_flags, push, pop,
`ifdef FLAG_COND_EN
        input  cond,
        output cond_true,
`endif
        output flags, flags_fwd, depth, stack_full, stack_empty, ovf_err, unf_err
    );
endinterface

// File: rtl/flag_stack_unit.sv
// -----------------------------------------------------------------------------
// flag_stack_unit
// Architectural condition-flag register with per-bit write masking, a
// same-cycle forwarded view (flags_fwd) for branch resolution, and a LIFO
// shadow stack that saves/restores flags on exception entry/return.
// Flag bit order MSB..LSB: negative, overflow, zero, carry_out.
//
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   reset  : synchronous, active-high reset
//   bus    : flag_stack_unit_if.slave (write controls, push/pop, status)
//
// Optional macro FLAG_COND_EN: adds cond[3:0] input and cond_true output,
// a condition-code evaluation on flags_fwd (needs NUM_FLAGS >= 4).
// -----------------------------------------------------------------------------
module flag_stack_unit #(
    parameter int NUM_FLAGS   = 4,
    parameter int STACK_DEPTH = 4,
    localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    flag_stack_unit_if.slave   bus
);

    if (STACK_DEPTH < 1) begin : g_depth_check
        $error("flag_stack_unit: STACK_DEPTH must be >= 1");
    end

    logic [NUM_FLAGS-1:0] r_flags;
    logic [DW-1:0]        r_depth;
    logic                 r_ovf;
    logic                 r_unf;
    // Plain register array: the top entry feeds flags_fwd combinationally,
    // so a registered-read memory cannot be used here.
    logic [NUM_FLAGS-1:0] r_stack [STACK_DEPTH];

    logic [NUM_FLAGS-1:0] w_masked;
    logic [NUM_FLAGS-1:0] w_top;
    logic [NUM_FLAGS-1:0] w_flags_next;
    logic [DW-1:0]        w_depth_next;
    logic [DW-1:0]        w_top_idx;
    logic [DW-1:0]        w_wr_idx;
    logic                 w_stack_we;
    logic                 w_set_ovf;
    logic                 w_set_unf;
    logic                 w_empty;
    logic                 w_full;

    assign w_empty   = (r_depth == '0);
    assign w_full    = (r_depth == DW'(STACK_DEPTH));
    assign w_top_idx = r_depth - DW'(1);
    assign w_masked  = (r_flags & ~bus.flag_mask) | (bus.alu_flags & bus.flag_mask);

    // Top-of-stack read mux; only consumed when the stack is not empty.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (w_top_idx == DW'(i)) begin
                w_top = r_stack[i];
            end
        end
    end

    // Next-state decode. A successful pop owns the flag register (restored
    // value wins over flag_we); push+pop on a non-empty stack is an exchange
    // of the top entry with the current flags.
    always_comb begin
        w_flags_next = r_flags;
        w_depth_next = r_depth;
        w_stack_we   = 1'b0;
        w_wr_idx     = r_depth;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        if (reset) begin
            w_flags_next = '0;
            w_depth_next = '0;
        end else if (bus.pop && !w_empty) begin
            w_flags_next = w_top;
            if (bus.push) begin
                w_stack_we = 1'b1;
                w_wr_idx   = w_top_idx;
            end else begin
                w_depth_next = r_depth - DW'(1);
            end
        end else begin
            if (bus.flag_we) begin
                w_flags_next = w_masked;
            end
            if (bus.pop) begin
                w_set_unf = 1'b1;
            end
            if (bus.push) begin
                if (!w_full) begin
                    w_stack_we   = 1'b1;
                    w_wr_idx     = r_depth;
                    w_depth_next = r_depth + DW'(1);
                end else begin
                    w_set_ovf = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_flags <= w_flags_next;
            r_depth <= w_depth_next;
            r_ovf   <= r_ovf | w_set_ovf;
            r_unf   <= r_unf | w_set_unf;
        end
    end

    // Stack entries: each slot captures the pre-update flags when addressed.
    // Contents are not reset; depth alone defines validity.
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
        always_ff @(posedge clk) begin
            if (w_stack_we && (w_wr_idx == DW'(gi))) begin
                r_stack[gi] <= r_flags;
            end
        end
    end

    assign bus.flags       = r_flags;
    assign bus.flags_fwd   = w_flags_next;
    assign bus.depth       = r_depth;
    assign bus.stack_full  = w_full & ~reset;
    assign bus.stack_empty = w_empty | reset;
    assign bus.ovf_err     = r_ovf;
    assign bus.unf_err     = r_unf;

`ifdef FLAG_COND_EN
    if (NUM_FLAGS < 4) begin : g_cond_check
        $error("flag_stack_unit: FLAG_COND_EN requires NUM_FLAGS >= 4");
    end else begin : g_cond
        logic w_n, w_v, w_z, w_c;
        logic w_cond;
        assign w_n = w_flags_next[3];
        assign w_v = w_flags_next[2];
        assign w_z = w_flags_next[1];
        assign w_c = w_flags_next[0];

        always_comb begin
            w_cond = 1'b0;
            case (bus.cond)
                4'd0:  w_cond = w_z;
                4'd1:  w_cond = ~w_z;
                4'd2:  w_cond = w_c;
                4'd3:  w_cond = ~w_c;
                4'd4:  w_cond = w_n;
                4'd5:  w_cond = ~w_n;
                4'd6:  w_cond = w_v;
                4'd7:  w_cond = ~w_v;
                4'd8:  w_cond = w_c & ~w_z;
                4'd9:  w_cond = ~w_c | w_z;
                4'd10: w_cond = (w_n == w_v);
                4'd11: w_cond = (w_n != w_v);
                4'd12: w_cond = ~w_z & (w_n == w_v);
                4'd13: w_cond = w_z | (w_n != w_v);
                4'd14: w_cond = 1'b1;
                default: w_cond = 1'b0;
            endcase
        end

        // Gated explicitly: codes like NE would otherwise be true on the
        // all-zero forwarded value during reset.
        assign bus.cond_true = w_cond & ~reset;
    end
`endif

endmodule

// File: doc/flag_stack_unit.md
Name: flag_stack_unit

Overview:
Parametrised successor to the per-flag enabled flag register. Holds the architectural condition flags with per-flag write masking. Adds a same-cycle forwarded view for branch resolution and a LIFO shadow stack that saves and restores flags on exception entry and return. Sits between the ALU flag outputs and the branch/condition logic in the datapath.

Parameters:
NUM_FLAGS, 4, number of flag bits; bit order MSB..LSB = negative, overflow, zero, carry_out (extra bits above are generic)
STACK_DEPTH, 4, number of shadow-stack entries; must be >= 1
DW, $clog2(STACK_DEPTH+1), width of the depth counter (derived; not overridden)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
flag_we  input  1  write ALU flags this cycle (the "Flag" enable of the old block)
flag_mask  input  NUM_FLAGS  per-bit write enable; a bit is written only when flag_we=1 and its mask bit=1
alu_flags  input  NUM_FLAGS  flags produced by the ALU this cycle
push  input  1  save the current flags to the stack
pop  input  1  restore flags from the top of the stack
flags  output  NUM_FLAGS  registered architectural flags
flags_fwd  output  NUM_FLAGS  combinational value that flags will take at the next edge
depth  output  DW  number of valid stack entries
stack_full  output  1  depth == STACK_DEPTH
stack_empty  output  1  depth == 0
ovf_err  output  1  sticky; set by push when full
unf_err  output  1  sticky; set by pop when empty

Behaviour:
- Reset (synchronous, active-high) clears flags, depth, ovf_err and unf_err to 0; stack contents are don't-care. During reset, stack_empty=1, stack_full=0, and flags_fwd=0.
- Masked write: next_flags = (flags & ~flag_mask) | (alu_flags & flag_mask) when flag_we=1. Otherwise flags hold. Latency is 1 cycle to flags and 0 cycles to flags_fwd.
- flags_fwd always equals the value flags will hold after the next edge, covering every case below.
- Push only, not full: stack[depth] <= flags (the pre-update value); depth+1. A flag_we in the same cycle still updates flags.
- Push when full: stack and depth unchanged; ovf_err <= 1; a same-cycle flag_we still applies.
- Pop only, not empty: flags <= stack[depth-1]; depth-1. Pop has priority over flag_we, so a same-cycle flag_we is discarded.
- Pop when empty: depth unchanged; unf_err <= 1; flags follow flag_we as normal.
- Push and pop together, not empty (exchange): stack[depth-1] <= flags, flags <= old stack[depth-1], depth unchanged, no error (legal when full). flag_we is discarded.
- Push and pop together, empty: the pop is ignored and unf_err <= 1; the push proceeds, so depth becomes 1 and the entry holds flags. The masked write still applies.
- Error flags are sticky until reset.
- There is no state machine beyond the depth counter.
- Stack storage is a register array indexed by depth, with no wrap-around.

Optional Feature:
FLAG_COND_EN
- When defined, adds input cond [3:0] and output cond_true [0:0]. cond_true is evaluated combinationally on flags_fwd using the codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- cond_true is 0 during reset.
- Requires NUM_FLAGS >= 4; elaboration error otherwise.
- When undefined, the ports are absent and no logic is generated.

Test Plan:
- Reset then flag_we=1, mask=4'b1111, alu_flags=4'b1010 -> flags_fwd=1010 in the same cycle; flags=1010 next cycle; depth=0, stack_empty=1.
- flags=1010; flag_we=1, mask=4'b0011, alu_flags=4'b0101 -> flags=1001.
- flags=1001; push together with flag_we (mask=1111, alu=0000) -> depth=1, flags=0000. Then pop with flag_we (alu=1111) -> flags=1001 (write discarded), depth=0.
- STACK_DEPTH=4: push 5 times with distinct flags 0001..0101 -> depth=4, stack_full=1, ovf_err=1 after the 5th push. Then 4 pops -> flags return 0100, 0011, 0010, 0001 in order. A 5th pop -> unf_err=1, flags unchanged.
- depth=2, top=0110, flags=1000; push and pop together -> flags=0110, top=1000, depth=2, no error. Assert reset mid-sequence -> next cycle all outputs 0, stack_empty=1.
- With FLAG_COND_EN defined: flags=0000, flag_we with alu=0010 (Z), cond=0 (EQ) -> cond_true=1 in the same cycle; cond=12 (GT) -> 0; alu=0000, cond=10 (GE) -> 1.
